spi_bus_arbiter: RTL

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

---
 rtl/spi_arb_pkg.sv | 15 +
 rtl/spi_arb_rr_pick.sv | 20 ++
 rtl/spi_bus_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-sensor SPI bus arbiter.
package spi_arb_pkg;

  localparam int unsigned NUM_REQ            = 2;
  localparam int unsigned DEF_GAP_CYCLES     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 3000;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StDrain,
    StGap
  } arb_state_e;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin pick between two requesters; the one not served last wins a tie.
module spi_arb_rr_pick
  import spi_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one spi_master between two sensor controllers with CS drain and inter-transaction gap.
// Optional grant timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic [NUM_REQ-1:0]   start,
  input  logic [NUM_REQ-1:0]   tx_valid,
  input  logic [8*NUM_REQ-1:0] tx_data,
  output logic [NUM_REQ-1:0]   tx_ready,
  output logic [NUM_REQ-1:0]   rx_valid,
  output logic [NUM_REQ-1:0]   busy,
  output logic [7:0]           rx_data,
  output logic                 m_start,
  output logic                 m_tx_valid,
  output logic [7:0]           m_tx_data,
  input  logic                 m_tx_ready,
  input  logic                 m_rx_valid,
  input  logic                 m_busy,
  input  logic [7:0]           m_rx_data,
  output logic [NUM_REQ-1:0]   cs_n,
  output logic                 timeout_err
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
  logic                last_q, last_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]  pick;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           to_err_q, to_err_d;
`endif

  spi_arb_rr_pick u_rr_pick (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cs_n_d    = cs_n_q;
    last_d    = last_q;
    gap_cnt_d = gap_cnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    to_err_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StOwn;
          gnt_d   = pick;
          cs_n_d  = ~pick;
          last_d  = pick[1];
`ifdef SPI_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      StOwn: begin
        if (!(|(req & gnt_q))) begin
          state_d = StDrain;
          gnt_d   = '0;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = StDrain;
          gnt_d    = '0;
          to_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
`endif
      end
      StDrain: begin
        // Chip select must stay low until the master has finished shifting.
        if (!m_busy) begin
          cs_n_d    = '1;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cs_n_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      cs_n_q    <= '1;
      last_q    <= 1'b1;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cs_n_q    <= cs_n_d;
      last_q    <= last_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;

  // Timeout depth has no effect in this build; this empty block only references it.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // gnt_q is non-zero only in StOwn, so master controls are zero in every other state.
  assign gnt        = gnt_q;
  assign cs_n       = cs_n_q;
  assign rx_data    = m_rx_data;
  assign m_start    = |(start & gnt_q);
  assign m_tx_valid = |(tx_valid & gnt_q);
  assign tx_ready   = gnt_q & {NUM_REQ{m_tx_ready}};
  assign rx_valid   = gnt_q & {NUM_REQ{m_rx_valid}};
  assign busy       = ~gnt_q | {NUM_REQ{m_busy}};

  always_comb begin
    m_tx_data = '0;
    unique case (gnt_q)
      2'b01:   m_tx_data = tx_data[7:0];
      2'b10:   m_tx_data = tx_data[15:8];
      default: m_tx_data = '0;
    endcase
  end

endmodule
